// File: rtl/muldiv_pkg.sv
// Shared encodings and sign helpers for the muldiv_unit M-extension block.
package muldiv_pkg;

  localparam int ITER_COUNT = 32;

  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } funct_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic [31:0] neg_if32(input logic neg, input logic [31:0] v);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] neg_if64(input logic neg, input logic [63:0] v);
    return neg ? (64'd0 - v) : v;
  endfunction

  // Multiplies run on magnitudes; restore the sign, then pick the low or high word.
  function automatic logic [31:0] mul_pick(input funct_e f, input logic neg, input logic [63:0] p);
    logic [63:0] s;
    s = neg_if64(neg, p);
    return (f == F_MUL) ? s[31:0] : s[63:32];
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned 32-bit restoring divider producing one quotient bit per step.
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic [4:0]  cnt;
  logic [32:0] trial;
  logic [32:0] diff;

  // Outputs are the post-step values, so the final step's result is usable in the same cycle.
  always_comb begin
    trial     = {rem, quo[31]};
    diff      = trial - {1'b0, dvsr};
    quotient  = {quo[30:0], ~diff[32]};
    remainder = diff[32] ? trial[31:0] : diff[31:0];
    done      = step & (cnt == 5'(ITER_COUNT - 1));
  end

  // Partial remainder, shifting dividend/quotient register and step counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem  <= 32'd0;
      quo  <= 32'd0;
      dvsr <= 32'd0;
      cnt  <= 5'd0;
    end else if (start) begin
      rem  <= 32'd0;
      quo  <= dividend;
      dvsr <= divisor;
      cnt  <= 5'd0;
    end else if (step) begin
      rem  <= remainder;
      quo  <= quotient;
      cnt  <= cnt + 5'd1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative divider and shift-add multiplier behind an IDLE/RUN/DONE FSM.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [2:0]  FunctE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  output logic        BusyE,
  output logic        DoneE,
  output logic [31:0] ResultE
);

  state_e      state, state_nxt;
  funct_e      f_in, op;
  logic        start, busy, is_mul_in, a_signed, b_signed, a_neg, b_neg;
  logic        div_zero, div_ovf, fast_mul, skip;
  logic        run_step, run_last, div_done, neg_res, neg_rem;
  logic [31:0] abs_a, abs_b, imm_result, run_result, div_q, div_r, mplier;
  logic [4:0]  count;
  logic [63:0] acc, mcand, acc_nxt;
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
`endif

  assign f_in  = funct_e'(FunctE);
  assign start = (state == S_IDLE) & StartE & ~FlushE;
  assign BusyE = busy & ~reset;

  // Operand magnitudes and the cases that finish without iterating.
  always_comb begin
    is_mul_in = ~FunctE[2];
    a_signed  = (f_in == F_MULH) | (f_in == F_MULHSU) | (f_in == F_DIV) | (f_in == F_REM);
    b_signed  = (f_in == F_MULH) | (f_in == F_DIV) | (f_in == F_REM);
    a_neg     = a_signed & SrcAE[31];
    b_neg     = b_signed & SrcBE[31];
    abs_a     = neg_if32(a_neg, SrcAE);
    abs_b     = neg_if32(b_neg, SrcBE);
    div_zero  = ~is_mul_in & (SrcBE == 32'd0);
    div_ovf   = ((f_in == F_DIV) | (f_in == F_REM)) &
                (SrcAE == 32'h8000_0000) & (SrcBE == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_MUL_EN
    fast_mul  = is_mul_in;
    fast_prod = {32'd0, abs_a} * {32'd0, abs_b};
`else
    fast_mul  = 1'b0;
`endif
    skip = div_zero | div_ovf | fast_mul;
    if (div_zero) begin
      imm_result = FunctE[1] ? SrcAE : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      imm_result = FunctE[1] ? 32'd0 : 32'h8000_0000;
    end else begin
`ifdef MULDIV_FAST_MUL_EN
      imm_result = mul_pick(f_in, a_neg ^ b_neg, fast_prod);
`else
      imm_result = 32'd0;
`endif
    end
  end

  // One iteration step and the sign-corrected result of the final step.
  always_comb begin
    acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    run_step = (state == S_RUN) & ~FlushE;
    run_last = (op[2] == 1'b0) ? (count == 5'(ITER_COUNT - 1)) : div_done;
    if (op[2] == 1'b0) begin
      run_result = mul_pick(op, neg_res, acc_nxt);
    end else if (op[1] == 1'b0) begin
      run_result = neg_if32(neg_res, div_q);
    end else begin
      run_result = neg_if32(neg_rem, div_r);
    end
  end

  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step      (run_step & op[2]),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Next-state and stall request; the stall is raised in the issue cycle itself.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          busy      = 1'b1;
          state_nxt = skip ? S_DONE : S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (FlushE) begin
          state_nxt = S_IDLE;
        end else if (run_last) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operation latch, multiplier datapath and registered result/done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op      <= F_MUL;
      count   <= 5'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= 64'd0;
      mcand   <= 64'd0;
      mplier  <= 32'd0;
      ResultE <= 32'd0;
      DoneE   <= 1'b0;
    end else begin
      DoneE <= 1'b0;
      if (start) begin
        op      <= f_in;
        count   <= 5'd0;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        acc     <= 64'd0;
        mcand   <= {32'd0, abs_a};
        mplier  <= abs_b;
        if (skip) begin
          ResultE <= imm_result;
          DoneE   <= 1'b1;
        end
      end else if (run_step) begin
        count  <= count + 5'd1;
        acc    <= acc_nxt;
        mcand  <= {mcand[62:0], 1'b0};
        mplier <= {1'b0, mplier[31:1]};
        if (run_last) begin
          ResultE <= run_result;
          DoneE   <= 1'b1;
        end
      end
    end
  end

endmodule
